// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: oversamples the SPI pins in the clk domain, decodes
// READ (0x03) and JEDEC-ID (0x9F) and streams bytes from a byte-wide memory port.
module spi_flash_responder #(
    parameter int          ADDR_W   = 24,
    parameter int          SYNC_STG = 2,
    parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err
);

    localparam int CNT_W = $clog2(ADDR_W);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_ID,
        ST_IGNORE
    } state_t;

    // valid_sync tracks when the cs_n synchroniser holds a real pin sample
    // rather than its reset preset.
    logic [SYNC_STG-1:0] sclk_sync;
    logic [SYNC_STG-1:0] cs_sync;
    logic [SYNC_STG-1:0] mosi_sync;
    logic [SYNC_STG-1:0] valid_sync;
    logic                sclk_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            cs_sync    <= '1;
            mosi_sync  <= '0;
            valid_sync <= '0;
            sclk_prev  <= 1'b0;
        end else begin
            sclk_sync  <= {sclk_sync[SYNC_STG-2:0], spi_sclk};
            cs_sync    <= {cs_sync[SYNC_STG-2:0], spi_cs_n};
            mosi_sync  <= {mosi_sync[SYNC_STG-2:0], spi_mosi};
            valid_sync <= {valid_sync[SYNC_STG-2:0], 1'b1};
            sclk_prev  <= sclk_sync[SYNC_STG-1];
        end
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sync_valid;
    logic sclk_rise;
    logic sclk_fall;

    assign sclk_s     = sclk_sync[SYNC_STG-1];
    assign cs_s       = cs_sync[SYNC_STG-1];
    assign mosi_s     = mosi_sync[SYNC_STG-1];
    assign sync_valid = valid_sync[SYNC_STG-1];
    assign sclk_rise  = sclk_s & ~sclk_prev;
    assign sclk_fall  = ~sclk_s & sclk_prev;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [ADDR_W-2:0]   rx_shift;
    logic [ADDR_W-1:0]   rx_word;
    logic [7:0]          tx_shift;
    logic [7:0]          tx_next;
    logic [7:0]          tx_cur;
    logic [2:0]          tx_cnt;
    logic [23:0]         id_shift;
    logic                first_byte;
    logic                rd_pend;
    logic                armed;

    assign rx_word = {rx_shift, mosi_s};
    assign tx_cur  = first_byte ? tx_shift : tx_next;
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            tx_next     <= '0;
            tx_cnt      <= '0;
            id_shift    <= '0;
            first_byte  <= 1'b0;
            rd_pend     <= 1'b0;
            armed       <= 1'b0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            cmd_err     <= 1'b0;
        end else begin
            mem_rd_en <= 1'b0;
            cmd_err   <= 1'b0;
            rd_pend   <= mem_rd_en;

            // Memory answers one cycle after the strobe; the first fetch of a
            // READ goes straight to the shifter, later ones are prefetches.
            if (rd_pend) begin
                if (first_byte) begin
                    tx_shift <= mem_rdata;
                end else begin
                    tx_next <= mem_rdata;
                end
            end

            if (cs_s) begin
                // A cs_n that was low at reset release only arms us once seen high.
                if (sync_valid) begin
                    armed <= 1'b1;
                end
                state       <= ST_IDLE;
                bit_cnt     <= '0;
                tx_cnt      <= '0;
                first_byte  <= 1'b0;
                spi_miso    <= 1'b0;
                spi_miso_oe <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (armed) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_word[ADDR_W-2:0];
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == CMD_LAST) begin
                                bit_cnt <= '0;
                                case (rx_word[7:0])
                                    8'h03: state <= ST_ADDR;
                                    8'h9F: begin
                                        state    <= ST_ID;
                                        id_shift <= JEDEC_ID;
                                    end
                                    default: begin
                                        state   <= ST_IGNORE;
                                        cmd_err <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_ADDR: begin
                        if (sclk_rise) begin
                            rx_shift <= rx_word[ADDR_W-2:0];
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == ADDR_LAST) begin
                                bit_cnt    <= '0;
                                mem_addr   <= rx_word;
                                mem_rd_en  <= 1'b1;
                                first_byte <= 1'b1;
                                tx_cnt     <= '0;
                                state      <= ST_READ;
                            end
                        end
                    end
                    ST_READ: begin
                        if (sclk_fall) begin
                            spi_miso_oe <= 1'b1;
                            tx_cnt      <= tx_cnt + 3'd1;
                            if (tx_cnt == 3'd0) begin
                                // Bit 7 of a new byte: launch the next prefetch.
                                spi_miso   <= tx_cur[7];
                                tx_shift   <= {tx_cur[6:0], 1'b0};
                                mem_addr   <= mem_addr + ADDR_W'(1);
                                mem_rd_en  <= 1'b1;
                                first_byte <= 1'b0;
                            end else begin
                                spi_miso <= tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end
                    end
                    ST_ID: begin
                        if (sclk_fall) begin
                            spi_miso_oe <= 1'b1;
                            spi_miso    <= id_shift[23];
                            id_shift    <= {id_shift[22:0], 1'b0};
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
